// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: handshake bus between the pipeline memory arbiter and
// the single-port unified memory.
//   MemReq   - request, held high until the MemReady cycle
//   MemWE    - write enable, valid with MemReq
//   MemAddr  - byte address, valid with MemReq
//   MemWData - store data, valid with MemReq
//   MemRData - read data, valid when MemReady=1
//   MemReady - transaction completes this cycle
// master = arbiter side, slave = memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            MemReq;
  logic            MemWE;
  logic [XLEN-1:0] MemAddr;
  logic [XLEN-1:0] MemWData;
  logic [XLEN-1:0] MemRData;
  logic            MemReady;

  modport master (
    output MemReq, MemWE, MemAddr, MemWData,
    input  MemRData, MemReady
  );

  modport slave (
    input  MemReq, MemWE, MemAddr, MemWData,
    output MemRData, MemReady
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port variable-latency memory between
// instruction fetch (F stage) and data load/store (M stage) of a 5-stage
// RV32I pipeline. Data accesses always win over fetch. The fetched
// instruction and the load data are held in registers; stall requests are
// produced for the hazard unit.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   PCF / InstrF    - fetch address / registered instruction for PCF
//   StallMemF       - fetch not yet satisfied (stall F/D)
//   ALUResultM, WriteDataM, MemWriteM, MemReadM - M-stage data access
//   ReadDataM       - registered load data
//   StallMemM       - data access outstanding (freeze all stages)
//   mem             - memory handshake bus (mem_port_arbiter_if.master)
//   MemTimeout      - sticky watchdog error
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   - a BUSY transaction not completed within TIMEOUT_CYCLES cycles
//               is abandoned and MemTimeout latches high until reset.
//   undefined - BUSY waits indefinitely; MemTimeout is tied low.
module mem_port_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [XLEN-1:0]     PCF,
  output logic [XLEN-1:0]     InstrF,
  output logic                StallMemF,
  input  logic [XLEN-1:0]     ALUResultM,
  input  logic [XLEN-1:0]     WriteDataM,
  input  logic                MemWriteM,
  input  logic                MemReadM,
  output logic [XLEN-1:0]     ReadDataM,
  output logic                StallMemM,
  mem_port_arbiter_if.master  mem,
  output logic                MemTimeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DATA_BUSY  = 2'd1,
    FETCH_BUSY = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_addr;
  logic            r_instr_valid;
  logic [XLEN-1:0] r_rdata;
  logic            r_data_served;

  logic            w_data_req;
  logic            w_instr_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen in the last BUSY cycle allowed before abandoning.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_mem_timeout;
`endif

  assign w_data_req  = MemReadM | MemWriteM;
  assign w_instr_hit = r_instr_valid & (r_instr_addr == PCF);

  assign StallMemM = w_data_req & ~r_data_served;
  assign StallMemF = ~w_instr_hit;

  assign InstrF    = r_instr;
  assign ReadDataM = r_rdata;

  assign mem.MemReq   = r_mem_req;
  assign mem.MemWE    = r_mem_we;
  assign mem.MemAddr  = r_mem_addr;
  assign mem.MemWData = r_mem_wdata;

`ifdef MEM_TIMEOUT_EN
  assign MemTimeout = r_mem_timeout;
`else
  assign MemTimeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_instr       <= '0;
      r_instr_addr  <= '0;
      r_instr_valid <= 1'b0;
      r_rdata       <= '0;
      r_data_served <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_tmo_cnt     <= '0;
      r_mem_timeout <= 1'b0;
`endif
    end else begin
      // dataServed lives for exactly one cycle: the cycle the pipeline
      // advances past the completed access. Completion below overrides this.
      r_data_served <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_data_req && !r_data_served) begin
            r_mem_addr  <= ALUResultM;
            r_mem_wdata <= WriteDataM;
            r_mem_we    <= MemWriteM;
            r_mem_req   <= 1'b1;
            r_state     <= DATA_BUSY;
`ifdef MEM_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end else if (!w_instr_hit) begin
            r_mem_addr  <= PCF;
            r_mem_we    <= 1'b0;
            r_mem_req   <= 1'b1;
            r_state     <= FETCH_BUSY;
`ifdef MEM_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end
        end

        DATA_BUSY: begin
          if (mem.MemReady) begin
            // Stores leave the previous load data untouched.
            if (!r_mem_we) begin
              r_rdata <= mem.MemRData;
            end
            r_data_served <= 1'b1;
            r_mem_req     <= 1'b0;
            r_state       <= IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            // Abandoned access still releases the pipeline.
            r_data_served <= 1'b1;
            r_mem_req     <= 1'b0;
            r_mem_timeout <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        FETCH_BUSY: begin
          // Tagged with the issued address, not the current PCF, so a
          // redirect during the fetch simply misses afterwards.
          if (mem.MemReady) begin
            r_instr       <= mem.MemRData;
            r_instr_addr  <= r_mem_addr;
            r_instr_valid <= 1'b1;
            r_mem_req     <= 1'b0;
            r_state       <= IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_mem_req     <= 1'b0;
            r_mem_timeout <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-by-cycle table of inputs and expected
// outputs against a memory responder with per-row wait-state count, followed
// by hand-written reset-mid-transaction and watchdog sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        StallMemF;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ReadDataM;
  logic        StallMemM;
  logic        MemTimeout;

  mem_port_arbiter_if #(.XLEN(32)) bus ();

  mem_port_arbiter #(
    .XLEN          (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PCF       (PCF),
    .InstrF    (InstrF),
    .StallMemF (StallMemF),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .MemWriteM (MemWriteM),
    .MemReadM  (MemReadM),
    .ReadDataM (ReadDataM),
    .StallMemM (StallMemM),
    .mem       (bus),
    .MemTimeout(MemTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: MemReady after mem_wait wait states of a request.
  int unsigned mem_wait;
  int unsigned busy_cnt;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    case (a)
      32'h0000_0000: rdata_of = 32'h0050_0093;
      32'h0000_0100: rdata_of = 32'hDEAD_BEEF;
      default:       rdata_of = {a[15:0], 16'hC0DE};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          busy_cnt <= 0;
    else if (bus.MemReq && !bus.MemReady) busy_cnt <= busy_cnt + 1;
    else                                 busy_cnt <= 0;
  end

  assign bus.MemReady = bus.MemReq && (busy_cnt >= mem_wait);
  assign bus.MemRData = bus.MemReady ? rdata_of(bus.MemAddr) : 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pcf;
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] wd;
    int unsigned lat;
    logic        stf;
    logic        stm;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] pcf, input logic rd, input logic wr,
                     input logic [31:0] alu, input logic [31:0] wd, input int unsigned lat,
                     input logic stf, input logic stm, input logic req, input logic we,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] instr, input logic [31:0] rdata);
    vec_t v;
    v = '{pcf, rd, wr, alu, wd, lat, stf, stm, req, we, addr, wdata, instr, rdata};
    vecs.push_back(v);
  endtask

  localparam logic [31:0] I0   = 32'h0050_0093;
  localparam logic [31:0] I4   = 32'h0004_C0DE;
  localparam logic [31:0] I10  = 32'h0010_C0DE;
  localparam logic [31:0] I40  = 32'h0040_C0DE;
  localparam logic [31:0] I44  = 32'h0044_C0DE;
  localparam logic [31:0] DB   = 32'hDEAD_BEEF;
  localparam logic [31:0] R104 = 32'h0104_C0DE;
  localparam logic [31:0] R108 = 32'h0108_C0DE;
  localparam logic [31:0] W    = 32'h1234_5678;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //   pcf  rd wr alu    wd lat | stf stm req we addr   wdata instr rdata
    // First fetch after reset, zero-wait memory.
    add(32'h0, 0,0, 32'h0,  0, 0,   1,0,0,0, 32'h0,   0, 32'h0, 32'h0);
    add(32'h0, 0,0, 32'h0,  0, 0,   1,0,1,0, 32'h0,   0, 32'h0, 32'h0);
    add(32'h0, 0,0, 32'h0,  0, 0,   0,0,0,0, 32'h0,   0, I0,    32'h0);
    // Load 0x100 with three wait states.
    add(32'h0, 1,0, 32'h100,0, 3,   0,1,0,0, 32'h0,   0, I0,    32'h0);
    add(32'h0, 1,0, 32'h100,0, 3,   0,1,1,0, 32'h100, 0, I0,    32'h0);
    add(32'h0, 1,0, 32'h100,0, 3,   0,1,1,0, 32'h100, 0, I0,    32'h0);
    add(32'h0, 1,0, 32'h100,0, 3,   0,1,1,0, 32'h100, 0, I0,    32'h0);
    add(32'h0, 1,0, 32'h100,0, 3,   0,1,1,0, 32'h100, 0, I0,    32'h0);
    add(32'h0, 1,0, 32'h100,0, 3,   0,0,0,0, 32'h100, 0, I0,    DB);
    // Back-to-back load gets its own transaction.
    add(32'h0, 1,0, 32'h104,0, 0,   0,1,0,0, 32'h100, 0, I0,    DB);
    add(32'h0, 1,0, 32'h104,0, 0,   0,1,1,0, 32'h104, 0, I0,    DB);
    add(32'h0, 1,0, 32'h104,0, 0,   0,0,0,0, 32'h104, 0, I0,    R104);
    // Store with fetch pending: store first, bubble, then fetch.
    add(32'h4, 0,1, 32'h200,W, 0,   1,1,0,0, 32'h104, 0, I0,    R104);
    add(32'h4, 0,1, 32'h200,W, 0,   1,1,1,1, 32'h200, W, I0,    R104);
    add(32'h4, 0,1, 32'h200,W, 0,   1,0,0,1, 32'h200, W, I0,    R104);
    add(32'h4, 0,0, 32'h0,  0, 0,   1,0,1,0, 32'h4,   W, I0,    R104);
    add(32'h4, 0,0, 32'h0,  0, 0,   0,0,0,0, 32'h4,   W, I4,    R104);
    // Redirect 0x10 -> 0x40 while fetching 0x10.
    add(32'h10,0,0, 32'h0,  0, 2,   1,0,0,0, 32'h4,   W, I4,    R104);
    add(32'h40,0,0, 32'h0,  0, 2,   1,0,1,0, 32'h10,  W, I4,    R104);
    add(32'h40,0,0, 32'h0,  0, 2,   1,0,1,0, 32'h10,  W, I4,    R104);
    add(32'h40,0,0, 32'h0,  0, 2,   1,0,1,0, 32'h10,  W, I4,    R104);
    add(32'h40,0,0, 32'h0,  0, 2,   1,0,0,0, 32'h10,  W, I10,   R104);
    add(32'h40,0,0, 32'h0,  0, 2,   1,0,1,0, 32'h40,  W, I10,   R104);
    add(32'h40,0,0, 32'h0,  0, 2,   1,0,1,0, 32'h40,  W, I10,   R104);
    add(32'h40,0,0, 32'h0,  0, 2,   1,0,1,0, 32'h40,  W, I10,   R104);
    add(32'h40,0,0, 32'h0,  0, 2,   0,0,0,0, 32'h40,  W, I40,   R104);
    // Load arrives during a fetch: fetch finishes first.
    add(32'h44,0,0, 32'h0,  0, 1,   1,0,0,0, 32'h40,  W, I40,   R104);
    add(32'h44,1,0, 32'h108,0, 1,   1,1,1,0, 32'h44,  W, I40,   R104);
    add(32'h44,1,0, 32'h108,0, 1,   1,1,1,0, 32'h44,  W, I40,   R104);
    add(32'h44,1,0, 32'h108,0, 1,   0,1,0,0, 32'h44,  W, I44,   R104);
    add(32'h44,1,0, 32'h108,0, 1,   0,1,1,0, 32'h108, 0, I44,   R104);
    add(32'h44,1,0, 32'h108,0, 1,   0,1,1,0, 32'h108, 0, I44,   R104);
    add(32'h44,1,0, 32'h108,0, 1,   0,0,0,0, 32'h108, 0, I44,   R108);
    add(32'h44,0,0, 32'h0,  0, 1,   0,0,0,0, 32'h108, 0, I44,   R108);

    rst_n = 1'b0;
    PCF = '0; ALUResultM = '0; WriteDataM = '0; MemWriteM = 1'b0; MemReadM = 1'b0;
    mem_wait = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_MemReq",    {31'b0, bus.MemReq}, 32'h0);
    chk("rst_InstrF",    InstrF,              32'h0);
    chk("rst_ReadDataM", ReadDataM,           32'h0);
    chk("rst_StallMemF", {31'b0, StallMemF},  32'h1);
    chk("rst_MemTimeout",{31'b0, MemTimeout}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      PCF        = vecs[i].pcf;
      MemReadM   = vecs[i].rd;
      MemWriteM  = vecs[i].wr;
      ALUResultM = vecs[i].alu;
      WriteDataM = vecs[i].wd;
      mem_wait   = vecs[i].lat;
      #1;
      chk($sformatf("row%0d_StallMemF", i), {31'b0, StallMemF},  {31'b0, vecs[i].stf});
      chk($sformatf("row%0d_StallMemM", i), {31'b0, StallMemM},  {31'b0, vecs[i].stm});
      chk($sformatf("row%0d_MemReq", i),    {31'b0, bus.MemReq}, {31'b0, vecs[i].req});
      chk($sformatf("row%0d_MemWE", i),     {31'b0, bus.MemWE},  {31'b0, vecs[i].we});
      chk($sformatf("row%0d_MemAddr", i),   bus.MemAddr,         vecs[i].addr);
      chk($sformatf("row%0d_MemWData", i),  bus.MemWData,        vecs[i].wdata);
      chk($sformatf("row%0d_InstrF", i),    InstrF,              vecs[i].instr);
      chk($sformatf("row%0d_ReadDataM", i), ReadDataM,           vecs[i].rdata);
      @(negedge clk);
    end

    // Asynchronous reset while a load is outstanding.
    PCF = 32'h80; MemReadM = 1'b1; ALUResultM = 32'h300; mem_wait = 5;
    @(negedge clk);
    #1;
    chk("mid_MemReq_busy", {31'b0, bus.MemReq}, 32'h1);
    chk("mid_MemAddr_busy", bus.MemAddr, 32'h300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_MemReq",    {31'b0, bus.MemReq}, 32'h0);
    chk("arst_MemAddr",   bus.MemAddr,         32'h0);
    chk("arst_InstrF",    InstrF,              32'h0);
    chk("arst_ReadDataM", ReadDataM,           32'h0);
    chk("arst_StallMemF", {31'b0, StallMemF},  32'h1);
    chk("arst_StallMemM", {31'b0, StallMemM},  32'h1);
    MemReadM = 1'b0;
    #1;
    chk("arst_StallMemM_norq", {31'b0, StallMemM}, 32'h0);

    // Load against a memory that never answers in time.
    @(negedge clk);
    rst_n = 1'b1;
    MemReadM = 1'b1; ALUResultM = 32'h400; mem_wait = 1000;
    #1;
    chk("tmo_c0_StallMemM", {31'b0, StallMemM},  32'h1);
    chk("tmo_c0_MemReq",    {31'b0, bus.MemReq}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("tmo_c%0d_MemReq", k),    {31'b0, bus.MemReq}, 32'h1);
      chk($sformatf("tmo_c%0d_StallMemM", k), {31'b0, StallMemM},  32'h1);
    end
    @(negedge clk);
    #1;
`ifdef MEM_TIMEOUT_EN
    chk("tmo_c5_MemReq",     {31'b0, bus.MemReq}, 32'h0);
    chk("tmo_c5_MemTimeout", {31'b0, MemTimeout}, 32'h1);
    chk("tmo_c5_StallMemM",  {31'b0, StallMemM},  32'h0);
    chk("tmo_c5_ReadDataM",  ReadDataM,           32'h0);
    MemReadM = 1'b0;
    @(negedge clk);
    #1;
    chk("tmo_c6_MemTimeout_sticky", {31'b0, MemTimeout}, 32'h1);
    chk("tmo_c6_MemReq_fetch",      {31'b0, bus.MemReq}, 32'h1);
    chk("tmo_c6_MemAddr_fetch",     bus.MemAddr,         32'h80);
`else
    chk("tmo_c5_MemReq",     {31'b0, bus.MemReq}, 32'h1);
    chk("tmo_c5_MemTimeout", {31'b0, MemTimeout}, 32'h0);
    chk("tmo_c5_StallMemM",  {31'b0, StallMemM},  32'h1);
    MemReadM = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
